// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and the timing bundle carried down the
// cam_frame_reader delay line.
//   H_*/V_*      : default 640x480@60 raster (visible, porches, sync)
//   IMG_W/IMG_H  : stored QVGA camera frame size
//   SYNC_POL     : active level of h_sync/v_sync (0 = active-low)
//   vga_tim_t    : {de, hs, vs, fs, x, y}; hs/vs are kept active-high internally
package vga_timing_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int IMG_W   = 320;
  localparam int IMG_H   = 240;

  localparam bit SYNC_POL = 1'b0;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } vga_tim_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus stage-0 decode.
//   clk, reset : pixel clock, synchronous active-high reset
//   tim_o      : decoded timing for the current counter position
//                (hs/vs active-high, x/y forced to 0 outside the visible area)
//   h_cnt_o    : horizontal counter 0..H_TOTAL-1
//   v_cnt_o    : vertical counter 0..V_TOTAL-1
module vga_timing_gen #(
  parameter int H_VIS  = vga_timing_pkg::H_VIS,
  parameter int H_FP   = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP   = vga_timing_pkg::H_BP,
  parameter int V_VIS  = vga_timing_pkg::V_VIS,
  parameter int V_FP   = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP   = vga_timing_pkg::V_BP
) (
  input  logic                     clk,
  input  logic                     reset,
  output vga_timing_pkg::vga_tim_t tim_o,
  output logic [9:0]               h_cnt_o,
  output logic [9:0]               v_cnt_o
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] H_HS_B  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_HS_E  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] V_VS_B  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_VS_E  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  vga_tim_t   tim_p0;

  // Line and frame wrap happen on the same edge, so there is no gap pixel.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: decode of the raw counters.
  always_comb begin
    tim_p0    = '0;
    tim_p0.de = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    tim_p0.hs = (h_cnt_q >= H_HS_B) && (h_cnt_q <= H_HS_E);
    tim_p0.vs = (v_cnt_q >= V_VS_B) && (v_cnt_q <= V_VS_E);
    tim_p0.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
    if (tim_p0.de) begin
      tim_p0.x = h_cnt_q;
      tim_p0.y = v_cnt_q;
    end
  end

  assign tim_o   = tim_p0;
  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/cam_frame_reader.sv
// Scans a VGA raster and fetches a 2x-upscaled QVGA RGB444 frame from the
// dual-bank frame buffer, producing pixel-aligned timing and colour for the
// colour filter stage. All outputs lag the raster counters by two clocks.
//   clk, reset          : pixel clock, synchronous active-high reset
//   bank_sel            : bank to display, taken only at frame start
//   rd_data             : BRAM read data {R,G,B}, valid 1 clk after rd_en
//   rd_en/rd_addr       : BRAM read enable / word address within the bank
//   rd_bank             : bank MSB, frame-stable copy of bank_sel
//   h_sync/v_sync       : syncs at SYNC_POL polarity
//   DE, x, y            : visible flag and pixel coordinates
//   cam_r/cam_g/cam_b   : pixel colour, 0 outside the visible area
//   frame_start         : one-clk pulse on output pixel (0,0)
module cam_frame_reader #(
  parameter int H_VIS    = vga_timing_pkg::H_VIS,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_VIS    = vga_timing_pkg::V_VIS,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bank_sel,
  input  logic [11:0] rd_data,
  output logic        rd_en,
  output logic [16:0] rd_addr,
  output logic        rd_bank,
  output logic        h_sync,
  output logic        v_sync,
  output logic        DE,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [3:0]  cam_r,
  output logic [3:0]  cam_g,
  output logic [3:0]  cam_b,
  output logic        frame_start
);
  import vga_timing_pkg::*;

  // Word address of the stored pixel: row*320 + col, with row/col already
  // halved for the 2x upscale. 320 = 256 + 64, so two shifts and an add.
  function automatic logic [16:0] pix_addr(input logic [8:0] col, input logic [8:0] row);
    logic [16:0] r;
    r = {8'd0, row};
    return (r << 8) + (r << 6) + {8'd0, col};
  endfunction

  vga_tim_t    tim_p0;
  logic [9:0]  h_cnt_p0, v_cnt_p0;

  vga_tim_t    tim_p1_q;
  logic        rd_en_p1_q;
  logic [16:0] rd_addr_p1_q;
  logic        rd_bank_q;

  vga_tim_t    tim_p2_q;

  vga_timing_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .tim_o   (tim_p0),
    .h_cnt_o (h_cnt_p0),
    .v_cnt_o (v_cnt_p0)
  );

  // Stage 0 -> 1: issue the BRAM read; address holds through blanking.
  // The bank is latched only at raster (0,0) so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      tim_p1_q     <= '0;
      rd_en_p1_q   <= 1'b0;
      rd_addr_p1_q <= '0;
      rd_bank_q    <= 1'b0;
    end else begin
      tim_p1_q   <= tim_p0;
      rd_en_p1_q <= tim_p0.de;
      if (tim_p0.de) rd_addr_p1_q <= pix_addr(h_cnt_p0[9:1], v_cnt_p0[9:1]);
      if (tim_p0.fs) rd_bank_q <= bank_sel;
    end
  end

  // Stage 1 -> 2: timing lines up with the BRAM data returning this clk.
  always_ff @(posedge clk) begin
    if (reset) tim_p2_q <= '0;
    else       tim_p2_q <= tim_p1_q;
  end

  assign rd_en       = rd_en_p1_q;
  assign rd_addr     = rd_addr_p1_q;
  assign rd_bank     = rd_bank_q;

  assign DE          = tim_p2_q.de;
  assign x           = tim_p2_q.x;
  assign y           = tim_p2_q.y;
  assign frame_start = tim_p2_q.fs;
  assign h_sync      = SYNC_POL ? tim_p2_q.hs : ~tim_p2_q.hs;
  assign v_sync      = SYNC_POL ? tim_p2_q.vs : ~tim_p2_q.vs;

  // Stale read data (blanking, just after reset) is masked by DE.
  assign cam_r = tim_p2_q.de ? rd_data[11:8] : 4'd0;
  assign cam_g = tim_p2_q.de ? rd_data[7:4]  : 4'd0;
  assign cam_b = tim_p2_q.de ? rd_data[3:0]  : 4'd0;

endmodule
